// File: rtl/aes_mix_pkg.sv
// Shared constants, types and GF(2^8) helper for the MixColumns engine.
package aes_mix_pkg;
    localparam int          AES_STATE_W  = 128;
    localparam int          AES_COL_W    = 32;
    localparam int          AES_NUM_COLS = 4;
    localparam logic [7:0]  GF_POLY      = 8'h1B;

    typedef logic [AES_COL_W-1:0] col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/mix_columns_engine_if.sv
// Handshake bundle between the round datapath and the MixColumns engine.
// The bypass signal exists only when MIX_COLUMNS_BYPASS_EN is defined.
interface mix_columns_engine_if import aes_mix_pkg::*; ();
    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_state;
    logic                   inv_mode;
`ifdef MIX_COLUMNS_BYPASS_EN
    logic                   bypass;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_state;

    // Upstream/downstream side (drives inputs, accepts results).
    modport master (
        output in_valid, in_state, inv_mode, out_ready,
`ifdef MIX_COLUMNS_BYPASS_EN
        output bypass,
`endif
        input  in_ready, out_valid, out_state
    );

    // Engine side.
    modport slave (
        input  in_valid, in_state, inv_mode, out_ready,
`ifdef MIX_COLUMNS_BYPASS_EN
        input  bypass,
`endif
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns.
// All multiples come from one xtime chain per byte, shared by both modes.
module mix_column_unit
    import aes_mix_pkg::*;
(
    input  col_t col_in,
    input  logic inv,
    output col_t col_out
);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign a[gi]  = col_in[31-8*gi -: 8];
            assign x2[gi] = xtime(a[gi]);
            assign x4[gi] = xtime(x2[gi]);
            assign x8[gi] = xtime(x4[gi]);
            assign m3[gi] = x2[gi] ^ a[gi];
            assign m9[gi] = x8[gi] ^ a[gi];
            assign mb[gi] = x8[gi] ^ x2[gi] ^ a[gi];
            assign md[gi] = x8[gi] ^ x4[gi] ^ a[gi];
            assign me[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
        end

        // Row r uses the coefficient vector rotated right by r.
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign col_out[31-8*gi -: 8] = inv ?
                (me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4]) :
                (x2[gi] ^ m3[(gi+1)%4] ^ a[(gi+2)%4]  ^ a[(gi+3)%4]);
        end
    endgenerate
endmodule

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns over a 128-bit state,
// COLS_PER_CYCLE columns per clock. Optional final-round pass-through
// is enabled by defining MIX_COLUMNS_BYPASS_EN.
module mix_columns_engine
    import aes_mix_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit REG_IN_MODE    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mix_columns_engine_if.slave  bus
);
    genvar gi;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         NUM_GROUPS = AES_NUM_COLS / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP   = 2'(NUM_GROUPS - 1);

    fsm_state_e             fsm_q, fsm_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] data_q, data_d, data_xf;
    logic                   mode_q, mode_d;
    logic                   bypass_q, bypass_d;
    logic                   accept;
    logic                   eff_inv;
    logic [1:0]             grp_base;
    col_t                   cur_cols [AES_NUM_COLS];
    col_t                   new_cols [AES_NUM_COLS];
    col_t                   unit_in  [COLS_PER_CYCLE];
    col_t                   unit_out [COLS_PER_CYCLE];

    assign bus.in_ready  = rst_n && ((fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && bus.out_ready));
    assign bus.out_valid = (fsm_q == ST_DONE);
    assign bus.out_state = data_q;
    assign accept        = bus.in_valid && bus.in_ready;
    // REG_IN_MODE=0 lets a test steer the mode live while the engine is busy.
    assign eff_inv       = REG_IN_MODE ? mode_q : bus.inv_mode;
    assign grp_base      = 2'(int'(cnt_q) * COLS_PER_CYCLE);

    generate
        for (gi = 0; gi < AES_NUM_COLS; gi++) begin : g_cols
            assign cur_cols[gi] = data_q[AES_STATE_W-1-AES_COL_W*gi -: AES_COL_W];
        end
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_units
            assign unit_in[gi] = cur_cols[grp_base + 2'(gi)];
            mix_column_unit u_col (
                .col_in  (unit_in[gi]),
                .inv     (eff_inv),
                .col_out (unit_out[gi])
            );
        end
    endgenerate

    // Replace the active column group in place; bypass keeps every column.
    always_comb begin
        for (int c = 0; c < AES_NUM_COLS; c++) new_cols[c] = cur_cols[c];
        if (!bypass_q) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) new_cols[grp_base + 2'(g)] = unit_out[g];
        end
        data_xf = '0;
        for (int c = 0; c < AES_NUM_COLS; c++) data_xf[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] = new_cols[c];
    end

    // Next-state logic: accept, step through column groups, hold result until taken.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        mode_d   = mode_q;
        bypass_d = bypass_q;
        case (fsm_q)
            ST_BUSY: begin
                data_d = data_xf;
                if (cnt_q == LAST_GRP) begin
                    cnt_d = 2'd0;
                    fsm_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (fsm_q == ST_DONE && bus.out_ready) fsm_d = ST_IDLE;
                if (accept) begin
                    data_d = bus.in_state;
                    mode_d = bus.inv_mode;
`ifdef MIX_COLUMNS_BYPASS_EN
                    bypass_d = bus.bypass;
`else
                    bypass_d = 1'b0;
`endif
                    cnt_d  = 2'd0;
                    fsm_d  = ST_BUSY;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight state immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= ST_IDLE;
            cnt_q    <= 2'd0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            bypass_q <= bypass_d;
        end
    end
endmodule
